sync_fifo_prog: RTL and testbench



---
 rtl/sync_fifo_prog.sv | 157 +++++++++++++++
 tb/tb_sync_fifo_prog.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags, synchronous flush and a standard or FWFT read port.
module sync_fifo_prog #(
  parameter int DATASIZE = 17,
  parameter int ADDRSIZE = 4,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wen,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                ren,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic [ADDRSIZE:0]   aempty_thresh,
  output logic [ADDRSIZE:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE + 1)'(DEPTH);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_acc, rd_acc;

  // Handshake: wen/ren are one-cycle requests with no back-pressure wait. A write is taken
  // when !full and a read when !empty (neither during clear); a refused request is dropped
  // and latches the matching sticky error flag. Flags are judged on the registered state.
  always_comb begin
    wr_acc   = wen && !full_q && !clear;
    rd_acc   = ren && !empty_q && !clear;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    full_d   = full_q;
    empty_d  = empty_q;
    afull_d  = afull_q;
    aempty_d = aempty_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      ovf_d    = ovf_q | (wen && full_q);
      unf_d    = unf_q | (ren && empty_q);
      // Flags follow next-count so they line up with count in the same cycle.
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      afull_d  = (afull_thresh != '0) && (count_d >= afull_thresh);
      aempty_d = (count_d <= aempty_thresh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata  = empty_q ? '0 : mem_q[rptr_q];
      assign rvalid = !empty_q;
    end else begin : g_std
      logic [DATASIZE-1:0] rdata_q, rdata_d;
      logic                rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (clear) begin
          rdata_d = '0;
        end else if (rd_acc) begin
          rdata_d  = mem_q[rptr_q];
          rvalid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard-read and FWFT instances share stimulus and are
// compared every cycle against a queue model plus a read-data scoreboard.
module tb_sync_fifo_prog;

  localparam int DW    = 17;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clear, wen, ren;
  logic [DW-1:0] wdata;
  logic [AW:0]   afull_thresh, aempty_thresh;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_rvalid, f_rvalid;
  logic [AW:0]   s_count, f_count;
  logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;

  sync_fifo_prog #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(s_rdata), .rvalid(s_rvalid), .afull_thresh(afull_thresh),
    .aempty_thresh(aempty_thresh), .count(s_count), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_prog #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(f_rdata), .rvalid(f_rvalid), .afull_thresh(afull_thresh),
    .aempty_thresh(aempty_thresh), .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .overflow(f_ovf), .underflow(f_unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model and scoreboard state
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_unf, m_racc;
  logic [DW-1:0] m_std_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_racc   = 1'b0;
    m_std_rd = '0;
  endtask

  task automatic check_outputs();
    int            n;
    logic          x_full, x_empty, x_afull, x_aempty;
    logic [DW-1:0] x_head;
    n        = mdl_q.size();
    x_full   = (n == DEPTH);
    x_empty  = (n == 0);
    x_afull  = (afull_thresh != 0) && (n >= int'(afull_thresh));
    x_aempty = (n <= int'(aempty_thresh));
    x_head   = (n != 0) ? mdl_q[0] : '0;
    check("s_count",  32'(s_count),  32'(n));
    check("s_full",   32'(s_full),   32'(x_full));
    check("s_empty",  32'(s_empty),  32'(x_empty));
    check("s_afull",  32'(s_afull),  32'(x_afull));
    check("s_aempty", 32'(s_aempty), 32'(x_aempty));
    check("s_ovf",    32'(s_ovf),    32'(m_ovf));
    check("s_unf",    32'(s_unf),    32'(m_unf));
    check("f_count",  32'(f_count),  32'(n));
    check("f_full",   32'(f_full),   32'(x_full));
    check("f_empty",  32'(f_empty),  32'(x_empty));
    check("f_afull",  32'(f_afull),  32'(x_afull));
    check("f_aempty", 32'(f_aempty), 32'(x_aempty));
    check("f_ovf",    32'(f_ovf),    32'(m_ovf));
    check("f_unf",    32'(f_unf),    32'(m_unf));
    // standard port: one rvalid pulse per accepted read, data popped from the scoreboard
    check("s_rvalid", 32'(s_rvalid), 32'(m_racc));
    if (s_rvalid) begin
      if (exp_q.size() == 0) check("s_sb_underrun", 32'(1), 32'(0));
      else m_std_rd = exp_q.pop_front();
    end
    check("s_rdata",  32'(s_rdata),  32'(m_std_rd));
    check("f_rvalid", 32'(f_rvalid), 32'(!x_empty));
    check("f_rdata",  32'(f_rdata),  32'(x_head));
  endtask

  // driver: inputs set at negedge, model stepped at posedge, outputs checked 1 unit later
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
    bit wa, ra;
    wen   = w;
    wdata = d;
    ren   = r;
    clear = clr;
    @(posedge clk);
    m_racc = 1'b0;
    if (clr) begin
      mdl_q.delete();
      exp_q.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_std_rd = '0;
    end else begin
      wa = w && (mdl_q.size() < DEPTH);
      ra = r && (mdl_q.size() > 0);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
      if (ra) begin
        exp_q.push_back(mdl_q.pop_front());
        m_racc = 1'b1;
      end
      if (wa) mdl_q.push_back(d);
    end
    #1 check_outputs();
    @(negedge clk);
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom);
  endfunction

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    wen           = 1'b0;
    ren           = 1'b0;
    wdata         = '0;
    afull_thresh  = 5'd14;
    aempty_thresh = 5'd2;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // fill to full, then one refused write
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 17'h1FFFF, 1'b0, 1'b0);
    // drain in order, then one refused read
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // single word into empty FIFO, then pop it
    cycle(1'b1, 17'h1ABCD, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // steady simultaneous traffic at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    // both requests while full, then while empty
    for (int i = 0; i < 11; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);

    // almost_full disabled while filling to full
    afull_thresh = 5'd0;
    for (int i = 0; i < 15; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    // flush at count 9 with overflow set, write in the same cycle is discarded
    cycle(1'b1, rnd_word(), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // random traffic with occasional flush and threshold changes
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        afull_thresh  = 5'($urandom_range(0, 16));
        aempty_thresh = 5'($urandom_range(0, 16));
      end
      cycle(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end

    // asynchronous reset in the middle of a write burst
    afull_thresh  = 5'd14;
    aempty_thresh = 5'd2;
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    wen   = 1'b1;
    wdata = rnd_word();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // normal operation resumes after reset
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
